// File: rtl/hw_trig_scheduler.sv
// Round-robin scheduler sharing one slow-clocked trigger target between NREQ fast-domain requesters.
// Optional build macro HWTRIG_TIMEOUT_EN adds a watchdog that aborts a trigger starved of slow edges.
module hw_trig_scheduler #(
  parameter int NREQ        = 4,
  parameter int SELW        = 2,
  parameter int GAP_CYC     = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic            wHClk_i,
  input  logic            wReset_i,
  input  logic            wLClk_i,
  input  logic [NREQ-1:0] wReq_i,
  input  logic [NREQ-1:0] wEnable_i,
  input  logic            wOvrClr_i,
  output logic            wTrig_o,
  output logic [SELW-1:0] wSel_o,
  output logic            wBusy_o,
  output logic            wDone_o,
  output logic [NREQ-1:0] wPend_o,
  output logic [NREQ-1:0] wOverrun_o,
  output logic            wTimeout_o,
  output logic [1:0]      wState_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] STRIG = 2'd1;
  localparam logic [1:0] LTRIG = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;
  localparam int GCW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  logic [2:0]        lclkSr;
  logic              slowEdge;
  logic [1:0]        state, stateNxt;
  logic [NREQ-1:0]   pend, pendNxt, ovr, ovrSet, gntVec;
  logic [2*NREQ-1:0] rot;
  logic [SELW-1:0]   lastGnt, gntIdx, sel;
  logic              gntFound, doneNxt, tmoHit;
  logic              trig, busy, done;
  logic [GCW-1:0]    gapCnt;

  // wLClk_i is only data here; stage 0 absorbs metastability before the edge compare.
  always_ff @(posedge wHClk_i) begin
    lclkSr <= {lclkSr[1:0], wLClk_i};
  end
  assign slowEdge = lclkSr[1] & ~lclkSr[2];

  // Rotate pending flags so bit 0 is the requester just after the last grant.
  always_comb begin
    int tmp;
    tmp      = 0;
    gntIdx   = lastGnt;
    gntFound = 1'b0;
    rot      = {pend, pend} >> (lastGnt + SELW'(1));
    for (int i = 0; i < NREQ; i++) begin
      if (!gntFound && rot[i]) begin
        gntFound = 1'b1;
        tmp      = int'(lastGnt) + 1 + i;
        if (tmp >= NREQ) tmp = tmp - NREQ;
        gntIdx   = SELW'(tmp);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      gntVec[i] = (state == IDLE) && gntFound && (gntIdx == SELW'(i));
    end
  end

  // A request landing on its own grant cycle re-arms the flag instead of counting as overrun.
  assign ovrSet  = wReq_i & wEnable_i & pend & ~gntVec;
  assign pendNxt = wEnable_i & (wReq_i | (pend & ~gntVec));

  always_comb begin
    stateNxt = state;
    doneNxt  = 1'b0;
    case (state)
      IDLE:  if (gntFound) stateNxt = STRIG;
      STRIG: begin
        if (slowEdge)    stateNxt = LTRIG;
        else if (tmoHit) stateNxt = IDLE;
      end
      LTRIG: begin
        if (slowEdge) begin
          doneNxt  = 1'b1;
          stateNxt = (GAP_CYC == 0) ? IDLE : GAP;
        end else if (tmoHit) begin
          stateNxt = IDLE;
        end
      end
      default: if (gapCnt == GCW'(GAP_CYC - 1)) stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge wHClk_i) begin
    if (wReset_i) begin
      state   <= IDLE;
      pend    <= '0;
      ovr     <= '0;
      lastGnt <= SELW'(NREQ - 1);
      sel     <= '0;
      trig    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      gapCnt  <= '0;
    end else begin
      state <= stateNxt;
      pend  <= pendNxt;
      ovr   <= ovrSet | (ovr & ~{NREQ{wOvrClr_i}});
      if ((state == IDLE) && gntFound) begin
        lastGnt <= gntIdx;
        sel     <= gntIdx;
      end
      trig   <= (stateNxt == STRIG) || (stateNxt == LTRIG);
      busy   <= (stateNxt != IDLE);
      done   <= doneNxt;
      gapCnt <= (state == GAP) ? gapCnt + GCW'(1) : '0;
    end
  end

`ifdef HWTRIG_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);
  logic [TCW-1:0] tmoCnt;
  logic           tmoFlag;

  assign tmoHit = ((state == STRIG) || (state == LTRIG)) && (tmoCnt == TCW'(TIMEOUT_CYC - 1));

  // Counter restarts on every slow edge, so it measures the gap between edges, not trigger length.
  always_ff @(posedge wHClk_i) begin
    if (wReset_i) begin
      tmoCnt  <= '0;
      tmoFlag <= 1'b0;
    end else begin
      if (((state == STRIG) || (state == LTRIG)) && !slowEdge) tmoCnt <= tmoCnt + TCW'(1);
      else                                                     tmoCnt <= '0;
      if (tmoHit && !slowEdge) tmoFlag <= 1'b1;
      else if (wOvrClr_i)      tmoFlag <= 1'b0;
    end
  end
  assign wTimeout_o = tmoFlag;
`else
  assign tmoHit     = 1'b0;
  assign wTimeout_o = 1'b0;
`endif

  assign wTrig_o    = trig;
  assign wSel_o     = sel;
  assign wBusy_o    = busy;
  assign wDone_o    = done;
  assign wPend_o    = pend;
  assign wOverrun_o = ovr;
  assign wState_o   = state;

endmodule

// File: tb/tb_hw_trig_scheduler.sv
// Directed bench for hw_trig_scheduler: grant-order vector table plus hand-written corner sequences.
module tb_hw_trig_scheduler;
  localparam int NREQ        = 4;
  localparam int SELW        = 2;
  localparam int GAP_CYC     = 8;
  localparam int TIMEOUT_CYC = 64;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LTRIG = 2'd2;

  logic            wHClk_i = 1'b0;
  logic            wReset_i;
  logic            wLClk_i = 1'b0;
  logic [NREQ-1:0] wReq_i;
  logic [NREQ-1:0] wEnable_i;
  logic            wOvrClr_i;
  logic            wTrig_o;
  logic [SELW-1:0] wSel_o;
  logic            wBusy_o;
  logic            wDone_o;
  logic [NREQ-1:0] wPend_o;
  logic [NREQ-1:0] wOverrun_o;
  logic            wTimeout_o;
  logic [1:0]      wState_o;

  int nChecks = 0;
  int nFail   = 0;
  logic lclkRun   = 1'b0;
  logic lclkForce = 1'b0;
  int   lclkCnt   = 0;

  typedef struct {
    string      name;
    logic [3:0] req;
    logic [3:0] en;
    int         nTrig;
    logic [7:0] sels;
  } vec_t;
  vec_t vecs[7];

  hw_trig_scheduler #(
    .NREQ(NREQ), .SELW(SELW), .GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .wHClk_i(wHClk_i), .wReset_i(wReset_i), .wLClk_i(wLClk_i), .wReq_i(wReq_i),
    .wEnable_i(wEnable_i), .wOvrClr_i(wOvrClr_i), .wTrig_o(wTrig_o), .wSel_o(wSel_o),
    .wBusy_o(wBusy_o), .wDone_o(wDone_o), .wPend_o(wPend_o), .wOverrun_o(wOverrun_o),
    .wTimeout_o(wTimeout_o), .wState_o(wState_o)
  );

  // Clock/reset block: fast clock period 10; slow clock period 10 fast cycles when running.
  always #5 wHClk_i = ~wHClk_i;

  always @(posedge wHClk_i) begin
    #2;
    if (lclkRun) begin
      if (lclkCnt == 4) begin
        lclkCnt = 0;
        wLClk_i = ~wLClk_i;
      end else begin
        lclkCnt++;
      end
    end else begin
      lclkCnt = 0;
      wLClk_i = lclkForce;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(posedge wHClk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic stopLclk();
    lclkRun   = 1'b0;
    lclkForce = 1'b0;
    repeat (4) step();
  endtask

  // Runs until the block is idle with nothing pending; the trigger already in progress is not counted.
  task automatic runUntilIdle(output int nTrig, output int nDone, output logic [7:0] sels,
                              output int unstable, output bit ok);
    logic            trigPrev;
    logic [SELW-1:0] cur;
    int              idle;
    nTrig = 0; nDone = 0; sels = '0; unstable = 0; ok = 1'b0; idle = 0;
    trigPrev = wTrig_o;
    cur      = wSel_o;
    for (int c = 0; c < 600; c++) begin
      step();
      if (wTrig_o && !trigPrev) begin
        if (nTrig < 4) sels[nTrig*2 +: 2] = wSel_o;
        cur = wSel_o;
        nTrig++;
      end else if (wTrig_o && (wSel_o !== cur)) begin
        unstable++;
      end
      if (wDone_o) nDone++;
      trigPrev = wTrig_o;
      if (!wBusy_o && !wTrig_o && (wPend_o == '0)) idle++;
      else idle = 0;
      if (idle >= 3) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic runVector(input int i);
    int nT, nD, unst;
    logic [7:0] got;
    bit ok;
    wEnable_i = vecs[i].en;
    wReq_i    = vecs[i].req;
    step();
    wReq_i = '0;
    runUntilIdle(nT, nD, got, unst, ok);
    check({vecs[i].name, "_settled"}, 32'(ok), 32'd1);
    check({vecs[i].name, "_count"}, 32'(nT), 32'(vecs[i].nTrig));
    check({vecs[i].name, "_done"}, 32'(nD), 32'(vecs[i].nTrig));
    for (int k = 0; k < vecs[i].nTrig; k++) begin
      check($sformatf("%s_sel%0d", vecs[i].name, k), 32'(got[k*2 +: 2]), 32'(vecs[i].sels[k*2 +: 2]));
    end
    check({vecs[i].name, "_sel_stable"}, 32'(unst), 32'd0);
    check({vecs[i].name, "_overrun"}, 32'(wOverrun_o), 32'd0);
    wEnable_i = 4'hF;
  endtask

  initial begin
    int nT, nD, unst, edges, gapBusy, hi;
    logic [7:0] got;
    logic lprev, fell, doneAtFall;
    bit ok;

    wReset_i = 1'b1; wReq_i = '0; wEnable_i = 4'hF; wOvrClr_i = 1'b0;
    lclkRun = 1'b1;
    repeat (3) step();
    check("rst_trig", 32'(wTrig_o), 32'd0);
    check("rst_sel", 32'(wSel_o), 32'd0);
    check("rst_busy", 32'(wBusy_o), 32'd0);
    check("rst_done", 32'(wDone_o), 32'd0);
    check("rst_pend", 32'(wPend_o), 32'd0);
    check("rst_overrun", 32'(wOverrun_o), 32'd0);
    check("rst_timeout", 32'(wTimeout_o), 32'd0);
    check("rst_state", 32'(wState_o), 32'(ST_IDLE));
    wReset_i = 1'b0;
    step();

    // Grant order follows from the round-robin pointer carried between vectors.
    vecs[0] = '{"all_four",  4'b1111, 4'b1111, 4, 8'hE4};
    vecs[1] = '{"req0",      4'b0001, 4'b1111, 1, 8'h00};
    vecs[2] = '{"req2",      4'b0100, 4'b1111, 1, 8'h02};
    vecs[3] = '{"wrap_0_2",  4'b0101, 4'b1111, 2, 8'h08};
    vecs[4] = '{"masked1",   4'b1010, 4'b1101, 1, 8'h03};
    vecs[5] = '{"req1_2",    4'b0110, 4'b1111, 2, 8'h09};
    vecs[6] = '{"masked3",   4'b1001, 4'b0111, 1, 8'h00};
    for (int i = 0; i < 7; i++) runVector(i);

    // Single trigger with the slow clock started after the rise: exactly two slow edges inside.
    stopLclk();
    wReq_i = 4'b0001;
    step();
    wReq_i = '0;
    check("t1_pend_visible", 32'(wPend_o), 32'h1);
    check("t1_trig_not_yet", 32'(wTrig_o), 32'd0);
    step();
    check("t1_trig_rise", 32'(wTrig_o), 32'd1);
    check("t1_sel", 32'(wSel_o), 32'd0);
    check("t1_busy", 32'(wBusy_o), 32'd1);
    check("t1_pend_cleared", 32'(wPend_o), 32'd0);
    lclkRun = 1'b1;
    edges = 0; gapBusy = 0; nD = 0; fell = 1'b0; doneAtFall = 1'b0; ok = 1'b0;
    lprev = wLClk_i;
    for (int c = 0; c < 200; c++) begin
      step();
      if (wDone_o) nD++;
      if (wTrig_o && wLClk_i && !lprev) edges++;
      lprev = wLClk_i;
      if (!wTrig_o) begin
        if (!fell) doneAtFall = wDone_o;
        fell = 1'b1;
        if (wBusy_o) gapBusy++;
        else begin
          ok = 1'b1;
          break;
        end
      end
    end
    check("t1_finished", 32'(ok), 32'd1);
    check("t1_slow_edges", 32'(edges), 32'd2);
    check("t1_done_count", 32'(nD), 32'd1);
    check("t1_done_at_fall", 32'(doneAtFall), 32'd1);
    check("t1_gap_busy", 32'(gapBusy), 32'(GAP_CYC));

    // Request repeated on its own grant cycle re-arms the flag without an overrun.
    wReq_i = 4'b0001;
    step();
    check("regrant_pend", 32'(wPend_o), 32'h1);
    step();
    wReq_i = '0;
    check("regrant_trig", 32'(wTrig_o), 32'd1);
    check("regrant_pend_kept", 32'(wPend_o), 32'h1);
    check("regrant_overrun", 32'(wOverrun_o), 32'd0);
    runUntilIdle(nT, nD, got, unst, ok);
    check("regrant_settled", 32'(ok), 32'd1);
    check("regrant_second", 32'(nT), 32'd1);
    check("regrant_sel", 32'(got[1:0]), 32'd0);

    // Overrun, clear, set-wins and enable flush while requester 0 is stuck in STRIG.
    stopLclk();
    wReq_i = 4'b0001;
    step();
    wReq_i = '0;
    step();
    check("ovr_setup_trig", 32'(wTrig_o), 32'd1);
    wReq_i = 4'b0010;
    step();
    wReq_i = '0;
    check("ovr_first_pend", 32'(wPend_o), 32'h2);
    check("ovr_first_clean", 32'(wOverrun_o), 32'd0);
    wReq_i = 4'b0010;
    step();
    wReq_i = '0;
    check("ovr_second", 32'(wOverrun_o), 32'h2);
    check("ovr_merged_pend", 32'(wPend_o), 32'h2);
    wOvrClr_i = 1'b1;
    step();
    wOvrClr_i = 1'b0;
    check("ovr_cleared", 32'(wOverrun_o), 32'd0);
    wReq_i = 4'b0010; wOvrClr_i = 1'b1;
    step();
    wReq_i = '0; wOvrClr_i = 1'b0;
    check("ovr_set_wins", 32'(wOverrun_o), 32'h2);
    wOvrClr_i = 1'b1;
    step();
    wOvrClr_i = 1'b0;
    check("ovr_cleared2", 32'(wOverrun_o), 32'd0);
    wEnable_i = 4'b1101;
    step();
    check("flush_pend", 32'(wPend_o), 32'd0);
    wReq_i = 4'b0010;
    step();
    wReq_i = '0;
    check("disabled_req_ignored", 32'(wPend_o), 32'd0);
    check("disabled_no_overrun", 32'(wOverrun_o), 32'd0);
    wEnable_i = 4'hF;
    lclkRun = 1'b1;
    runUntilIdle(nT, nD, got, unst, ok);
    check("flush_settled", 32'(ok), 32'd1);
    check("flush_no_trigger", 32'(nT), 32'd0);
    check("flush_done_current", 32'(nD), 32'd1);

    // Reset while in LTRIG.
    stopLclk();
    wReq_i = 4'b0001;
    step();
    wReq_i = '0;
    step();
    check("rstmid_trig", 32'(wTrig_o), 32'd1);
    wReq_i = 4'b0100;
    step();
    wReq_i = '0;
    check("rstmid_pend", 32'(wPend_o), 32'h4);
    lclkForce = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (wState_o == ST_LTRIG) break;
    end
    check("rstmid_in_ltrig", 32'(wState_o), 32'(ST_LTRIG));
    wReset_i = 1'b1;
    step();
    wReset_i = 1'b0;
    check("rstmid_trig_low", 32'(wTrig_o), 32'd0);
    check("rstmid_busy_low", 32'(wBusy_o), 32'd0);
    check("rstmid_pend_clear", 32'(wPend_o), 32'd0);
    check("rstmid_no_done", 32'(wDone_o), 32'd0);
    lclkForce = 1'b0;
    lclkRun   = 1'b1;
    nD = 0; hi = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (wDone_o) nD++;
      if (wTrig_o) hi++;
    end
    check("rstmid_done_after", 32'(nD), 32'd0);
    check("rstmid_trig_after", 32'(hi), 32'd0);

    // Slow clock held low for a long stretch.
    stopLclk();
    wReq_i = 4'b0001;
    step();
    wReq_i = '0;
    step();
    check("stall_trig", 32'(wTrig_o), 32'd1);
`ifdef HWTRIG_TIMEOUT_EN
    hi = 1; nD = 0;
    for (int c = 0; c < 300; c++) begin
      step();
      if (wDone_o) nD++;
      if (wTrig_o) hi++;
      else break;
    end
    check("tmo_trig_cycles", 32'(hi), 32'(TIMEOUT_CYC));
    check("tmo_flag", 32'(wTimeout_o), 32'd1);
    check("tmo_no_done", 32'(nD), 32'd0);
    check("tmo_no_gap", 32'(wBusy_o), 32'd0);
    wOvrClr_i = 1'b1;
    step();
    wOvrClr_i = 1'b0;
    check("tmo_cleared", 32'(wTimeout_o), 32'd0);
`else
    nD = 0;
    for (int c = 0; c < 2 * TIMEOUT_CYC; c++) begin
      step();
      if (wDone_o) nD++;
    end
    check("stall_still_trig", 32'(wTrig_o), 32'd1);
    check("stall_still_busy", 32'(wBusy_o), 32'd1);
    check("stall_no_timeout", 32'(wTimeout_o), 32'd0);
    check("stall_no_done", 32'(nD), 32'd0);
    wReset_i = 1'b1;
    step();
    wReset_i = 1'b0;
    check("stall_reset_trig", 32'(wTrig_o), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
